control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter READ_CYCLES, default 1, which sets the number of cycles Read is held per memory read (range 1-4).
REQ-002 SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port clear, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ir, input, 32 bits: the datapath IR. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
REQ-005 SHALL have port opcode, output, 5 bits: the ALU operation select.
REQ-006 SHALL have outputs PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, Cout, each 1 bit: bus source selects.
REQ-007 SHALL have outputs Gra, Grb, Grc, Rin, Rout, BAout, each 1 bit: register-file select/encode controls.
REQ-008 SHALL have outputs MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, each 1 bit: register load enables.
REQ-009 SHALL have outputs IncPC, Read, Write, each 1 bit: PC increment and memory strobes.
REQ-010 SHALL have output Run, 1 bit: high while executing, low once halted.

Function
REQ-011 SHALL be a Moore FSM with states RST, T0-T7 and HALT; outputs SHALL decode from state plus ir[31:27] only.
REQ-012 SHALL sequence any unlisted output as 0 in every state.
REQ-013 SHALL sequence fetch as follows:
- T0: PCout, MARin, IncPC.
- T1: Read, MDRin, held READ_CYCLES cycles by a down-counter.
- T2: MDRout, IRin.
REQ-014 SHALL sequence R-type (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011) as follows:
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, opcode=ir[31:27], ZLowIn.
- T5: Zlowout, Gra, Rin.
- Then T0.
REQ-015 SHALL sequence immediate ops (addi 01100, andi 01101, ori 01110) as R-type, except T4 drives Cout instead of Grc/Rout.
REQ-016 SHALL sequence unary ops (neg 10001, not 10010) as follows:
- T3: Grb, Rout, opcode, ZLowIn.
- T4: Zlowout, Gra, Rin.
- Then T0.
REQ-017 SHALL sequence ld 00000 as follows:
- T3: Grb, BAout, Yin.
- T4: Cout, opcode=00011, ZLowIn.
- T5: Zlowout, MARin.
- T6: Read, MDRin, held READ_CYCLES cycles.
- T7: MDRout, Gra, Rin.
- Then T0.
REQ-018 SHALL sequence ldi 00001 as ld T3-T4, then T5: Zlowout, Gra, Rin, then T0.
REQ-019 SHALL sequence st 00010 as follows:
- T3-T5: as ld.
- T6: Gra, Rout, MDRin (Read=0).
- T7: Write for exactly 1 cycle.
- Then T0.
REQ-020 SHALL sequence mul 10000 / div 01111 as follows:
- T3: Gra, Rout, Yin.
- T4: Grb, Rout, opcode, ZHighIn, ZLowIn.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
- Then T0.
REQ-021 SHALL treat halt 11011 as: after T2 enter HALT, hold Run=0 with all strobes 0, and leave HALT only on clear.
REQ-022 SHALL treat nop 11010 and any undefined opcode as: T2 -> T0, with no register load.
REQ-023 SHALL drive opcode=0 in every state not listed above.
REQ-024 SHALL never assert Read and Write in the same cycle, and never assert more than one bus source at a time.

Reset
REQ-025 SHALL, while clear=1, immediately force state RST, set all outputs 0, clear the read counter and set Run=1, irrespective of clock.
REQ-026 SHALL advance RST -> T0 on the first rising edge after clear deasserts.
REQ-027 SHALL, if clear asserts mid-instruction, abort that instruction; no remaining strobes of it SHALL appear.

Configuration
REQ-028 SHALL, with macro CONTROL_SEQUENCER_MULDIV_EN defined, implement REQ-020.
REQ-029 SHALL, without CONTROL_SEQUENCER_MULDIV_EN, decode mul/div as nop (REQ-022), and never assert HIin, LOin or ZHighIn.

Structure
REQ-030 SHALL place the opcode constants, the state enumeration and the IR field positions in shared package cpu_pkg, which is also used by the ALU.
REQ-031 SHALL implement the read-hold counter as sub-module read_wait_counter (load READ_CYCLES, count down, done flag).

Verification
REQ-032 SHALL cover: ir=0x18918000 (add R1,R2,R3), READ_CYCLES=1 -> 6 cycles T0-T5; ZLowIn with opcode=00011 in cycle 5; Gra+Rin in cycle 6; then PCout.
REQ-033 SHALL cover: ir=0x01000055 (ld R2,0x55(R0)) -> BAout+Yin at T3; Cout+ZLowIn at T4; MARin at T5; Read at T6; Gra+Rin+MDRout at T7; 8 cycles total.
REQ-034 SHALL cover: ir=0x81A00000 (mul R3,R4), READ_CYCLES=2, macro defined -> Read high exactly 2 cycles in fetch; LOin at T5; HIin at T6; 8 cycles total.
REQ-035 SHALL cover: same ir with the macro undefined -> return to T0 after T2; HIin, LOin and ZHighIn never asserted.
REQ-036 SHALL cover: ir=0xD8000000 (halt) -> Run=0 from the cycle after T2; no PCout for 20 cycles; clear pulse -> Run=1, PCout 1 cycle after release.
REQ-037 SHALL cover: clear asserted asynchronously in T4 of add -> all outputs 0 before the next edge; no ZLowIn or Rin follows; fetch restarts at T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU definitions: IR fields, opcodes, sequencer states
//
// Shared by the control sequencer and the ALU.
//   - IR field bit positions (opcode, Ra, Rb, Rc, C)
//   - 5-bit opcode constants
//   - state_t : control sequencer states RST, T0-T7, HALT
//   - iclass_t / decode_class() : groups opcodes by the step sequence they use
package cpu_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int C_MSB   = 18;
    localparam int C_LSB   = 0;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_RTYPE, CL_IMM, CL_UNARY, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_HALT
    } iclass_t;

    function automatic iclass_t decode_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:        return CL_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:               return CL_IMM;
            OP_NEG, OP_NOT:                         return CL_UNARY;
            OP_LD:                                  return CL_LD;
            OP_LDI:                                 return CL_LDI;
            OP_ST:                                  return CL_ST;
            OP_MUL, OP_DIV:                         return CL_MULDIV;
            OP_HALT:                                return CL_HALT;
            default:                                return CL_NOP;
        endcase
    endfunction

endpackage

// File: rtl/read_wait_counter.sv
// rtl/read_wait_counter.sv - down-counter that stretches a memory read strobe
//
// Ports:
//   clock  - system clock
//   clear  - asynchronous active-high reset, forces the count to 0
//   load   - reload the count with READ_CYCLES-1 (asserted whenever no read is held)
//   hold   - a read is being held this cycle; count down towards 0
//   done   - count has reached 0: this is the last cycle of the read
module read_wait_counter #(
    parameter int READ_CYCLES = 1
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic hold,
    output logic done
);

    localparam logic [1:0] INIT = 2'(READ_CYCLES - 1);

    logic [1:0] count;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= 2'd0;
        end else if (load) begin
            count <= INIT;
        end else if (hold && (count != 2'd0)) begin
            count <= count - 2'd1;
        end
    end

    assign done = (count == 2'd0);

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore control sequencer for the bus-based CPU datapath
//
// Build option: CONTROL_SEQUENCER_MULDIV_EN enables the mul/div step sequence;
// without it mul/div decode as nop and HIin/LOin/ZHighIn stay low.
//
// Ports:
//   clock        - system clock, rising edge
//   clear        - asynchronous active-high reset (state RST, all strobes 0, Run=1)
//   ir[31:0]     - datapath instruction register; only ir[31:27] is decoded
//   opcode[4:0]  - ALU operation select
//   PCout..Cout  - bus source selects (at most one per cycle)
//   Gra..BAout   - register-file select/encode controls
//   MARin..ZLowIn- register load enables
//   IncPC, Read, Write - PC increment and memory strobes
//   Run          - high while executing, low in HALT
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int READ_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    output logic [4:0]  opcode,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Yout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHighIn,
    output logic        ZLowIn,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Run
);

    state_t      state;
    state_t      next;
    iclass_t     cls;
    logic [4:0]  op;
    logic        rd_hold;
    logic        rd_done;
    logic        unused_ir;

    assign op        = ir[OPC_MSB:OPC_LSB];
    assign unused_ir = ^ir[RA_MSB:C_LSB];

`ifdef CONTROL_SEQUENCER_MULDIV_EN
    assign cls = decode_class(op);
`else
    assign cls = (decode_class(op) == CL_MULDIV) ? CL_NOP : decode_class(op);
`endif

    // Memory reads (fetch T1, ld T6) stay in their state until the counter expires;
    // the counter is reloaded in every other cycle so it is always primed.
    assign rd_hold = (state == T1) || ((state == T6) && (cls == CL_LD));

    read_wait_counter #(
        .READ_CYCLES(READ_CYCLES)
    ) u_read_wait (
        .clock (clock),
        .clear (clear),
        .load  (!rd_hold),
        .hold  (rd_hold),
        .done  (rd_done)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= RST;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next     = state;
        opcode   = 5'd0;
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Yout     = 1'b0;
        Cout     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        BAout    = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ZHighIn  = 1'b0;
        ZLowIn   = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        Run      = (state != HALT);

        case (state)
            RST: next = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
                next  = T1;
            end
            T1: begin
                Read = 1'b1; MDRin = 1'b1;
                if (rd_done) next = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                case (cls)
                    CL_HALT: next = HALT;
                    CL_NOP:  next = T0;
                    default: next = T3;
                endcase
            end
            T3: begin
                next = T4;
                case (cls)
                    CL_RTYPE, CL_IMM: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    CL_UNARY: begin
                        Grb = 1'b1; Rout = 1'b1; opcode = op; ZLowIn = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    CL_MULDIV: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    default: next = T0;
                endcase
            end
            T4: begin
                next = T5;
                case (cls)
                    CL_RTYPE: begin
                        Grc = 1'b1; Rout = 1'b1; opcode = op; ZLowIn = 1'b1;
                    end
                    CL_IMM: begin
                        Cout = 1'b1; opcode = op; ZLowIn = 1'b1;
                    end
                    CL_UNARY: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        next = T0;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        // effective address = base + C through the adder
                        Cout = 1'b1; opcode = OP_ADD; ZLowIn = 1'b1;
                    end
                    CL_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; opcode = op;
                        ZHighIn = 1'b1; ZLowIn = 1'b1;
                    end
                    default: next = T0;
                endcase
            end
            T5: begin
                next = T0;
                case (cls)
                    CL_RTYPE, CL_IMM, CL_LDI: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                        next = T6;
                    end
                    CL_MULDIV: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                        next = T6;
                    end
                    default: ;
                endcase
            end
            T6: begin
                next = T0;
                case (cls)
                    CL_LD: begin
                        Read = 1'b1; MDRin = 1'b1;
                        next = rd_done ? T7 : T6;
                    end
                    CL_ST: begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                        next = T7;
                    end
                    CL_MULDIV: begin
                        Zhighout = 1'b1; HIin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T7: begin
                next = T0;
                case (cls)
                    CL_LD: begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    CL_ST:   Write = 1'b1;
                    default: ;
                endcase
            end
            HALT:    next = HALT;
            default: next = RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer (READ_CYCLES 1 and 2)
module tb_control_sequencer;

    localparam int B_PCOUT = 0,  B_ZHOUT = 1,  B_ZLOUT = 2,  B_MDROUT = 3;
    localparam int B_HIOUT = 4,  B_LOOUT = 5,  B_YOUT = 6,   B_COUT = 7;
    localparam int B_GRA = 8,    B_GRB = 9,    B_GRC = 10,   B_RIN = 11;
    localparam int B_ROUT = 12,  B_BAOUT = 13, B_MARIN = 14, B_PCIN = 15;
    localparam int B_MDRIN = 16, B_IRIN = 17,  B_YIN = 18,   B_HIIN = 19;
    localparam int B_LOIN = 20,  B_ZHIN = 21,  B_ZLIN = 22,  B_INCPC = 23;
    localparam int B_READ = 24,  B_WRITE = 25, B_RUN = 26;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    wire  [26:0] s1, s2;
    wire  [4:0]  op1, op2;
    wire  [31:0] obs1 = {op1, s1};
    wire  [31:0] obs2 = {op2, s2};

    logic [31:0] q1[$];
    logic [31:0] q2[$];
    int tests  = 0;
    int errors = 0;

    control_sequencer #(.READ_CYCLES(1)) dut1 (
        .clock(clock), .clear(clear), .ir(ir), .opcode(op1),
        .PCout(s1[B_PCOUT]), .Zhighout(s1[B_ZHOUT]), .Zlowout(s1[B_ZLOUT]),
        .MDRout(s1[B_MDROUT]), .HIout(s1[B_HIOUT]), .LOout(s1[B_LOOUT]),
        .Yout(s1[B_YOUT]), .Cout(s1[B_COUT]), .Gra(s1[B_GRA]), .Grb(s1[B_GRB]),
        .Grc(s1[B_GRC]), .Rin(s1[B_RIN]), .Rout(s1[B_ROUT]), .BAout(s1[B_BAOUT]),
        .MARin(s1[B_MARIN]), .PCin(s1[B_PCIN]), .MDRin(s1[B_MDRIN]), .IRin(s1[B_IRIN]),
        .Yin(s1[B_YIN]), .HIin(s1[B_HIIN]), .LOin(s1[B_LOIN]), .ZHighIn(s1[B_ZHIN]),
        .ZLowIn(s1[B_ZLIN]), .IncPC(s1[B_INCPC]), .Read(s1[B_READ]),
        .Write(s1[B_WRITE]), .Run(s1[B_RUN])
    );

    control_sequencer #(.READ_CYCLES(2)) dut2 (
        .clock(clock), .clear(clear), .ir(ir), .opcode(op2),
        .PCout(s2[B_PCOUT]), .Zhighout(s2[B_ZHOUT]), .Zlowout(s2[B_ZLOUT]),
        .MDRout(s2[B_MDROUT]), .HIout(s2[B_HIOUT]), .LOout(s2[B_LOOUT]),
        .Yout(s2[B_YOUT]), .Cout(s2[B_COUT]), .Gra(s2[B_GRA]), .Grb(s2[B_GRB]),
        .Grc(s2[B_GRC]), .Rin(s2[B_RIN]), .Rout(s2[B_ROUT]), .BAout(s2[B_BAOUT]),
        .MARin(s2[B_MARIN]), .PCin(s2[B_PCIN]), .MDRin(s2[B_MDRIN]), .IRin(s2[B_IRIN]),
        .Yin(s2[B_YIN]), .HIin(s2[B_HIIN]), .LOin(s2[B_LOIN]), .ZHighIn(s2[B_ZHIN]),
        .ZLowIn(s2[B_ZLIN]), .IncPC(s2[B_INCPC]), .Read(s2[B_READ]),
        .Write(s2[B_WRITE]), .Run(s2[B_RUN])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] m(input int b);
        return 32'd1 << b;
    endfunction

    function automatic logic [31:0] opc(input logic [4:0] o);
        return {o, 27'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic p(input int w, input logic [31:0] v, input bit run = 1'b1);
        logic [31:0] x;
        x = run ? (v | m(B_RUN)) : v;
        if (w == 1) q1.push_back(x);
        else        q2.push_back(x);
    endtask

    task automatic push_fetch(input int w, input int rc);
        p(w, m(B_PCOUT) | m(B_MARIN) | m(B_INCPC));
        for (int i = 0; i < rc; i++) p(w, m(B_READ) | m(B_MDRIN));
        p(w, m(B_MDROUT) | m(B_IRIN));
    endtask

    // Reference step sequence of one instruction, from fetch to the following T0.
    task automatic gen(input int w, input logic [4:0] o, input int rc);
        push_fetch(w, rc);
        case (o) inside
            [5'd3:5'd11]: begin
                p(w, m(B_GRB) | m(B_ROUT) | m(B_YIN));
                p(w, m(B_GRC) | m(B_ROUT) | m(B_ZLIN) | opc(o));
                p(w, m(B_ZLOUT) | m(B_GRA) | m(B_RIN));
            end
            [5'd12:5'd14]: begin
                p(w, m(B_GRB) | m(B_ROUT) | m(B_YIN));
                p(w, m(B_COUT) | m(B_ZLIN) | opc(o));
                p(w, m(B_ZLOUT) | m(B_GRA) | m(B_RIN));
            end
            5'd17, 5'd18: begin
                p(w, m(B_GRB) | m(B_ROUT) | m(B_ZLIN) | opc(o));
                p(w, m(B_ZLOUT) | m(B_GRA) | m(B_RIN));
            end
            5'd0, 5'd1, 5'd2: begin
                p(w, m(B_GRB) | m(B_BAOUT) | m(B_YIN));
                p(w, m(B_COUT) | m(B_ZLIN) | opc(5'd3));
                if (o == 5'd1) begin
                    p(w, m(B_ZLOUT) | m(B_GRA) | m(B_RIN));
                end else begin
                    p(w, m(B_ZLOUT) | m(B_MARIN));
                    if (o == 5'd0) begin
                        for (int i = 0; i < rc; i++) p(w, m(B_READ) | m(B_MDRIN));
                        p(w, m(B_MDROUT) | m(B_GRA) | m(B_RIN));
                    end else begin
                        p(w, m(B_GRA) | m(B_ROUT) | m(B_MDRIN));
                        p(w, m(B_WRITE));
                    end
                end
            end
`ifdef CONTROL_SEQUENCER_MULDIV_EN
            5'd15, 5'd16: begin
                p(w, m(B_GRA) | m(B_ROUT) | m(B_YIN));
                p(w, m(B_GRB) | m(B_ROUT) | m(B_ZHIN) | m(B_ZLIN) | opc(o));
                p(w, m(B_ZLOUT) | m(B_LOIN));
                p(w, m(B_ZHOUT) | m(B_HIIN));
            end
`endif
            5'd27: begin
                for (int i = 0; i < 20; i++) p(w, 32'd0, 1'b0);
            end
            default: ;
        endcase
        if (o != 5'd27) p(w, m(B_PCOUT) | m(B_MARIN) | m(B_INCPC));
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((q1.size() != 0 || q2.size() != 0) && guard < 100) begin
            @(negedge clock);
            if (q1.size() != 0) check({tag, "/rc1"}, obs1, q1.pop_front());
            if (q2.size() != 0) check({tag, "/rc2"}, obs2, q2.pop_front());
            guard++;
        end
        if (guard >= 100) begin
            check({tag, "/timeout"}, 32'(q1.size() + q2.size()), 32'd0);
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic start(input logic [31:0] v);
        @(negedge clock);
        clear = 1'b1;
        ir    = v;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] v, input string tag);
        start(v);
        gen(1, v[31:27], 1);
        gen(2, v[31:27], 2);
        drain(tag);
    endtask

    initial begin
        clear = 1'b1;
        ir    = 32'd0;
        repeat (2) @(negedge clock);
        check("reset/rc1", obs1, m(B_RUN));
        check("reset/rc2", obs2, m(B_RUN));

        run_instr(32'h18918000, "add");
        run_instr(32'h01000055, "ld");
        run_instr(32'h08800010, "ldi");
        run_instr(32'h10800010, "st");
        run_instr(32'h61000005, "addi");
        run_instr(32'h89000000, "neg");
        run_instr(32'h81A00000, "mul");
        run_instr(32'h79A00000, "div");
        run_instr(32'hD0000000, "nop");
        run_instr(32'hF8000000, "undef");

        // halt, then an asynchronous clear pulse restarts fetch
        run_instr(32'hD8000000, "halt");
        @(negedge clock);
        #2 clear = 1'b1;
        #1;
        check("halt_clr/rc1", obs1, m(B_RUN));
        check("halt_clr/rc2", obs2, m(B_RUN));
        @(negedge clock);
        clear = 1'b0;
        p(1, m(B_PCOUT) | m(B_MARIN) | m(B_INCPC));
        p(2, m(B_PCOUT) | m(B_MARIN) | m(B_INCPC));
        drain("halt_restart");

        // add aborted by clear during T4 (rc2 instance sits exactly in T4)
        start(32'h18918000);
        for (int w = 1; w <= 2; w++) begin
            push_fetch(w, w);
            p(w, m(B_GRB) | m(B_ROUT) | m(B_YIN));
            p(w, m(B_GRC) | m(B_ROUT) | m(B_ZLIN) | opc(5'd3));
        end
        drain("abort_pre");
        #2 clear = 1'b1;
        #1;
        check("abort_clr/rc1", obs1, m(B_RUN));
        check("abort_clr/rc2", obs2, m(B_RUN));
        @(negedge clock);
        check("abort_held/rc2", obs2, m(B_RUN));
        clear = 1'b0;
        gen(1, 5'd3, 1);
        gen(2, 5'd3, 2);
        drain("abort_post");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end

endmodule
